// File: rtl/quad_debounce_decoder.sv
// Quadrature encoder front end: sync, debounce, detent decode.
// Ports: clk, rst_n, canalA/B raw pins; giro*/err_quad pulses, ready.
module quad_debounce_decoder #(
  parameter int DEB_CYCLES       = 50000,
  parameter int STEPS_PER_DETENT = 4,
  parameter int CNT_W            = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic canalA,
  input  logic canalB,
  output logic giroPositivo,
  output logic giroNegativo,
  output logic err_quad,
  output logic ready
);

  localparam int INIT_W = $clog2(DEB_CYCLES + 3);
  localparam int ACC_W  = $clog2(STEPS_PER_DETENT) + 2;

  localparam logic [INIT_W-1:0] INIT_LAST =
    INIT_W'(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    ACC_W'(STEPS_PER_DETENT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // bit 1 = channel A, bit 0 = channel B
  logic [1:0]        meta_q;
  logic [1:0]        sync_q;
  logic [1:0]        filt_q;
  logic [1:0]        filt_d;
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  state_e                   state_q, state_d;
  logic [INIT_W-1:0]        init_q, init_d;
  logic [1:0]               prev_q, prev_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pos_q, pos_d;
  logic                     neg_q, neg_d;
  logic                     err_q, err_d;
  logic                     rdy_q, rdy_d;

  // Gray code {A,B} -> position 0..3 along the CW direction
  function automatic logic [1:0] gpos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0] delta;
  logic       step_cw;
  logic       step_ccw;
  logic       step_bad;

  assign delta    = gpos(filt_q) - gpos(prev_q);
  assign step_cw  = (delta == 2'd1);
  assign step_ccw = (delta == 2'd3);
  assign step_bad = (delta == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {canalA, canalB};
      sync_q <= meta_q;
    end
  end

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == INIT) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    rdy_d   = rdy_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      INIT: begin
        acc_d = '0;
        if (init_q == INIT_LAST) begin
          prev_d  = filt_q;
          rdy_d   = 1'b1;
          state_d = RUN;
        end else begin
          init_d = init_q + INIT_W'(1);
        end
      end
      RUN: begin
        prev_d = filt_q;
        // reversals fall out naturally: acc only
        // pulses at the far end of its own direction
        unique case (1'b1)
          step_cw: begin
            if (acc_q == ACC_MAX) begin
              pos_d = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = acc_q + ACC_ONE;
            end
          end
          step_ccw: begin
            if (acc_q == ACC_MIN) begin
              neg_d = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = acc_q - ACC_ONE;
            end
          end
          step_bad: begin
            err_d = 1'b1;
            acc_d = '0;
          end
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      init_q  <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      rdy_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      rdy_q   <= rdy_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign giroPositivo = pos_q;
  assign giroNegativo = neg_q;
  assign err_quad     = err_q;
  assign ready        = rdy_q;

endmodule

// File: tb/tb_quad_debounce_decoder.sv
// Directed bench for quad_debounce_decoder with DEB_CYCLES=4.
// Expected pulses are queued with their due cycle and matched live.
module tb_quad_debounce_decoder;

  localparam int DEB = 4;
  localparam int LAT = 2 + DEB + 1;

  localparam int K_NONE = 0;
  localparam int K_POS  = 1;
  localparam int K_NEG  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic canalA = 1'b0;
  logic canalB = 1'b0;
  logic giroPositivo;
  logic giroNegativo;
  logic err_quad;
  logic ready;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  quad_debounce_decoder #(
    .DEB_CYCLES(DEB),
    .STEPS_PER_DETENT(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .canalA(canalA),
    .canalB(canalB),
    .giroPositivo(giroPositivo),
    .giroNegativo(giroNegativo),
    .err_quad(err_quad),
    .ready(ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Any pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    int   obs;
    exp_t e;
    if (giroPositivo || giroNegativo || err_quad) begin
      obs = giroPositivo ? K_POS :
            giroNegativo ? K_NEG : K_ERR;
      chk("pos_neg_excl",
          int'(giroPositivo && giroNegativo), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", obs, K_NONE);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", obs, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset(input logic a, input logic b);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    canalA = a;
    canalB = b;
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_pos", int'(giroPositivo), 0);
    chk("rst_neg", int'(giroNegativo), 0);
    chk("rst_err", int'(err_quad), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("ready_early", int'(ready), 0);
    @(negedge clk);
    chk("ready_rise", int'(ready), 1);
  endtask

  task automatic step(input logic a, input logic b,
                      input int kind);
    exp_t e;
    @(negedge clk);
    canalA = a;
    canalB = b;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
    end
    repeat (9) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);

    // idle at 11 through init: ready only
    do_reset(1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // full CW detent from 00
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b0, K_NONE);
    step(1'b1, 1'b1, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b0, 1'b0, K_POS);

    // 3-cycle glitch on A must be swallowed
    @(negedge clk);
    canalA = 1'b1;
    repeat (3) @(negedge clk);
    canalA = 1'b0;
    repeat (15) @(negedge clk);

    // partial CW then back: acc returns to 0
    step(1'b1, 1'b0, K_NONE);
    step(1'b1, 1'b1, K_NONE);
    step(1'b1, 1'b0, K_NONE);
    step(1'b0, 1'b0, K_NONE);
    step(1'b1, 1'b0, K_NONE);
    step(1'b1, 1'b1, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b0, 1'b0, K_POS);

    // illegal 00->11, then CCW detent from 11
    step(1'b1, 1'b1, K_ERR);
    step(1'b1, 1'b0, K_NONE);
    step(1'b0, 1'b0, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b1, 1'b1, K_NEG);

    // illegal jump with acc=1 must clear acc
    step(1'b0, 1'b1, K_NONE);
    step(1'b1, 1'b0, K_ERR);
    step(1'b0, 1'b0, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b1, 1'b1, K_NONE);
    step(1'b1, 1'b0, K_NEG);

    // reset after 3 CW steps discards the partial detent
    step(1'b1, 1'b1, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b0, 1'b0, K_NONE);
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b0, K_NONE);
    repeat (10) @(negedge clk);
    step(1'b1, 1'b1, K_NONE);
    step(1'b0, 1'b1, K_NONE);
    step(1'b0, 1'b0, K_POS);

    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_debounce_decoder.md
QUAD_DEBOUNCE_DECODER -- requirements
Module: quad_debounce_decoder

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning consecutive stable cycles a channel change needs before it is accepted (1 ms at 50 MHz).
REQ-002 SHALL have parameter STEPS_PER_DETENT, default 4, meaning valid quadrature transitions per reported detent.
REQ-003 SHALL have parameter CNT_W, default 16, meaning debounce counter width; DEB_CYCLES SHALL fit in CNT_W bits.
REQ-004 SHALL have port clk, input, 1, meaning 50 MHz system clock; the block uses one clock.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port canalA, input, 1, meaning raw asynchronous encoder channel A.
REQ-007 SHALL have port canalB, input, 1, meaning raw asynchronous encoder channel B.
REQ-008 SHALL have port giroPositivo, output, 1, meaning one-cycle pulse per completed clockwise detent.
REQ-009 SHALL have port giroNegativo, output, 1, meaning one-cycle pulse per completed counter-clockwise detent.
REQ-010 SHALL have port err_quad, output, 1, meaning one-cycle pulse on an illegal quadrature jump.
REQ-011 SHALL have port ready, output, 1, meaning high once initialisation is done and decoding is active.

Function
REQ-012 SHALL pass each channel through a 2-flop synchroniser before any other logic.
REQ-013 SHALL hold a per-channel filtered bit and counter: synced == filtered -> counter cleared; otherwise counter increments; on the cycle the counter reaches DEB_CYCLES-1 with synced still differing, filtered <= synced and counter <= 0.
REQ-014 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-015 SHALL, in INIT, load filtered bits directly from the synced values each cycle, count DEB_CYCLES+2 cycles, then capture prev_state <= {filtered A, filtered B}, assert ready, and enter RUN; no output pulses occur in INIT.
REQ-016 SHALL, in RUN, compare cur = {fA,fB} with prev_state each cycle, then set prev_state <= cur.
REQ-017 SHALL treat 00->10->11->01->00 (A leads B) as clockwise and the reverse as counter-clockwise steps.
REQ-018 SHALL keep a signed step accumulator, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1).
REQ-019 SHALL, on a CW step with acc == STEPS_PER_DETENT-1, pulse giroPositivo and clear acc; otherwise acc + 1.
REQ-020 SHALL, on a CCW step with acc == -(STEPS_PER_DETENT-1), pulse giroNegativo and clear acc; otherwise acc - 1.
REQ-021 SHALL, on a direction reversal mid-detent, only move acc toward the new direction without emitting a pulse.
REQ-022 SHALL, on an illegal transition (both bits change), pulse err_quad, clear acc, emit no direction pulse, and adopt cur as prev_state.
REQ-023 SHALL register all outputs; each pulse appears exactly 1 cycle after the filtered state change that causes it, high for exactly 1 cycle.
REQ-024 SHALL never assert giroPositivo and giroNegativo in the same cycle.
REQ-025 SHALL produce a total latency from raw pin edge to pulse of 2 (sync) + DEB_CYCLES (filter) + 1 (output) cycles.

Reset
REQ-026 SHALL, while rst_n = 0, force giroPositivo = 0, giroNegativo = 0, err_quad = 0, ready = 0, acc = 0, counters = 0, synchronisers/filtered = 0, state = INIT.
REQ-027 SHALL, on reset assertion mid-detent, discard the partial accumulation; no pulse is emitted after release until a full new detent completes.

Verification (DEB_CYCLES = 4, STEPS_PER_DETENT = 4)
REQ-028 Bench SHALL cover: reset released with A = B = 1 -> ready rises after 6 cycles, no pulses, no err_quad.
REQ-029 Bench SHALL cover: from 00, CW sequence 10, 11, 01, 00, each held 10 cycles -> exactly one giroPositivo pulse, 7 cycles after the final 00 edge.
REQ-030 Bench SHALL cover: glitch of 3 cycles on canalA -> filtered value unchanged, no pulses, no error.
REQ-031 Bench SHALL cover: 00->10->11 then back 11->10->00 -> acc returns to 0, no direction pulse.
REQ-032 Bench SHALL cover: 00 -> 11 directly (both pins together) -> single err_quad pulse, acc = 0, then a full CCW detent -> one giroNegativo pulse.
REQ-033 Bench SHALL cover: rst_n pulsed low after 3 CW steps -> outputs 0 immediately, and the next single CW step after ready produces no pulse.
